// File: rtl/mem_interface.sv
// -----------------------------------------------------------------------------
// mem_interface
//
// Memory access sequencer sitting between the control unit and the datapath's
// MAR/MDR pair. A one-cycle read or write request accepted in IDLE latches
// the MAR address (and MDR write data), strobes a synchronous RAM for exactly
// one cycle and reports completion with a one-cycle done pulse. On reads the
// returned RAM word is captured into m_data_in and presented to the MDR with
// the mdr_in / md_mux_select strobes.
//
// Parameters
//   REG_SIZE    data/address word width (matches the datapath)
//   ADDR_WIDTH  RAM address bits taken from addr_in[ADDR_WIDTH-1:0]
//   MEM_LAT     RAM read latency in cycles after the mem_re strobe edge (1..15)
//
// Ports
//   clk            in   rising-edge clock for all state
//   reset          in   synchronous reset, active-high
//   rd_req         in   read request, sampled only in IDLE
//   wr_req         in   write request, sampled only in IDLE (read wins a tie)
//   addr_in        in   MAR output
//   wdata_in       in   MDR output (write data)
//   busy           out  high in every non-IDLE state
//   done           out  one-cycle completion pulse
//   addr_err       out  one-cycle out-of-range pulse (address check build only)
//   m_data_in      out  registered read data to the MDR
//   mdr_in         out  MDR load enable, one cycle per completed read
//   md_mux_select  out  MDR input select (1 = memory), mirrors mdr_in
//   mem_addr       out  RAM address, latched at accept
//   mem_wdata      out  RAM write data, latched at write accept
//   mem_re         out  RAM read strobe
//   mem_we         out  RAM write strobe
//   mem_rdata      in   RAM read data
//
// Build option
//   MEM_ADDR_CHECK_EN  when defined, an accepted request whose addr_in has any
//                      bit set above ADDR_WIDTH goes to ERR instead of touching
//                      the RAM and pulses addr_err together with done. When
//                      undefined the upper address bits are ignored, the ERR
//                      state does not exist and addr_err is tied low.
// -----------------------------------------------------------------------------
module mem_interface #(
  parameter int REG_SIZE   = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int MEM_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_req,
  input  logic                  wr_req,
  input  logic [REG_SIZE-1:0]   addr_in,
  input  logic [REG_SIZE-1:0]   wdata_in,
  output logic                  busy,
  output logic                  done,
  output logic                  addr_err,
  output logic [REG_SIZE-1:0]   m_data_in,
  output logic                  mdr_in,
  output logic                  md_mux_select,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_SIZE-1:0]   mem_wdata,
  output logic                  mem_re,
  output logic                  mem_we,
  input  logic [REG_SIZE-1:0]   mem_rdata
);

  // Wait counter counts MEM_LAT-1 down to 0, so it needs clog2(MEM_LAT+1) bits.
  localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

`ifdef MEM_ADDR_CHECK_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_STB  = 3'd1,
    RD_WAIT = 3'd2,
    RD_DONE = 3'd3,
    WR_STB  = 3'd4,
    WR_DONE = 3'd5,
    ERR     = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_STB  = 3'd1,
    RD_WAIT = 3'd2,
    RD_DONE = 3'd3,
    WR_STB  = 3'd4,
    WR_DONE = 3'd5
  } state_t;
`endif

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;

  // A request is taken only while IDLE; anything seen elsewhere is dropped.
  logic accept;
  logic rd_accept;
  logic wait_last;

  // Registered-output next values, all derived from the next state so every
  // strobe lines up with the state it belongs to.
  logic busy_nxt;
  logic done_nxt;
  logic mem_re_nxt;
  logic mem_we_nxt;
  logic mdr_nxt;

`ifdef MEM_ADDR_CHECK_EN
  logic addr_bad;
  logic addr_err_nxt;
  assign addr_bad = |addr_in[REG_SIZE-1:ADDR_WIDTH];
`else
  // Upper MAR bits carry no meaning when the range check is not built.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_in[REG_SIZE-1:ADDR_WIDTH];
`endif

  assign accept    = (state == IDLE) && (rd_req || wr_req);
  assign rd_accept = accept && rd_req;
  assign wait_last = (state == RD_WAIT) && (cnt == '0);

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_nxt = state;

    unique case (state)
      IDLE: begin
        if (accept) begin
`ifdef MEM_ADDR_CHECK_EN
          if (addr_bad)    state_nxt = ERR;
          else
`endif
          if (rd_req)      state_nxt = RD_STB;
          else             state_nxt = WR_STB;
        end
      end
      RD_STB:              state_nxt = RD_WAIT;
      RD_WAIT: begin
        if (cnt == '0)     state_nxt = RD_DONE;
      end
      RD_DONE:             state_nxt = IDLE;
      WR_STB:              state_nxt = WR_DONE;
      WR_DONE:             state_nxt = IDLE;
`ifdef MEM_ADDR_CHECK_EN
      ERR:                 state_nxt = IDLE;
`endif
      default:             state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_nxt   = (state_nxt != IDLE);
    mem_re_nxt = (state_nxt == RD_STB);
    mem_we_nxt = (state_nxt == WR_STB);
    mdr_nxt    = (state_nxt == RD_DONE);
    done_nxt   = (state_nxt == RD_DONE) || (state_nxt == WR_DONE);
`ifdef MEM_ADDR_CHECK_EN
    addr_err_nxt = (state_nxt == ERR);
    if (state_nxt == ERR) done_nxt = 1'b1;
`endif
  end

  // ---------------------------------------------------------------------------
  // State, counter and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      mem_re        <= 1'b0;
      mem_we        <= 1'b0;
      mdr_in        <= 1'b0;
      md_mux_select <= 1'b0;
      m_data_in     <= '0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
    end else begin
      state         <= state_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      mem_re        <= mem_re_nxt;
      mem_we        <= mem_we_nxt;
      mdr_in        <= mdr_nxt;
      md_mux_select <= mdr_nxt;

      // Loaded only on RD_STB -> RD_WAIT and stops at zero, so it never wraps.
      if (state == RD_STB)
        cnt <= CNT_LOAD;
      else if ((state == RD_WAIT) && (cnt != '0))
        cnt <= cnt - 1'b1;

      // RAM word is valid on the edge that leaves RD_WAIT.
      if (wait_last)
        m_data_in <= mem_rdata;

      // Address and write data are frozen from accept until the next accept;
      // a read that wins a tie leaves the write data untouched.
      if (accept)
        mem_addr <= addr_in[ADDR_WIDTH-1:0];
      if (accept && !rd_accept)
        mem_wdata <= wdata_in;
    end
  end

`ifdef MEM_ADDR_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) addr_err <= 1'b0;
    else       addr_err <= addr_err_nxt;
  end
`else
  assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_interface.sv
// -----------------------------------------------------------------------------
// tb_mem_interface
//
// Two sequencer instances (MEM_LAT = 1 and MEM_LAT = 4), each attached to its
// own behavioural synchronous RAM with a read pipeline of the matching depth.
// Expected behaviour comes from a transaction-level model: a shadow memory
// per instance plus the latched address / write data / last read word, and a
// per-transaction timeline computed from the latency arithmetic (strobe in the
// first cycle after accept, done MEM_LAT+2 cycles after accept for reads,
// 2 cycles for writes).
// -----------------------------------------------------------------------------
module tb_mem_interface;

  localparam int RS = 32;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]         rd_req, wr_req;
  logic [1:0][RS-1:0] addr_in, wdata_in;
  logic [1:0]         busy, done, addr_err, mdr_in, md_mux_select, mem_re, mem_we;
  logic [1:0][RS-1:0] m_data_in, mem_wdata, mem_rdata;
  logic [1:0][AW-1:0] mem_addr;

  logic        ram_init;
  logic [31:0] ram_seed;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ ram_seed;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 4;

    logic [RS-1:0]        ram [512];
    logic [L-1:0][RS-1:0] pipe;

    mem_interface #(.REG_SIZE(RS), .ADDR_WIDTH(AW), .MEM_LAT(L)) u_dut (
      .clk           (clk),
      .reset         (reset),
      .rd_req        (rd_req[g]),
      .wr_req        (wr_req[g]),
      .addr_in       (addr_in[g]),
      .wdata_in      (wdata_in[g]),
      .busy          (busy[g]),
      .done          (done[g]),
      .addr_err      (addr_err[g]),
      .m_data_in     (m_data_in[g]),
      .mdr_in        (mdr_in[g]),
      .md_mux_select (md_mux_select[g]),
      .mem_addr      (mem_addr[g]),
      .mem_wdata     (mem_wdata[g]),
      .mem_re        (mem_re[g]),
      .mem_we        (mem_we[g]),
      .mem_rdata     (mem_rdata[g])
    );

    // Synchronous RAM: read sampled on the strobe edge, word emerges L cycles
    // later; outside that window the read port carries junk.
    always @(posedge clk) begin
      if (ram_init) begin
        for (int i = 0; i < 512; i++) ram[i] <= init_word(i);
      end else if (mem_we[g]) begin
        ram[mem_addr[g]] <= mem_wdata[g];
      end
      pipe[0] <= mem_re[g] ? ram[mem_addr[g]] : $urandom();
      for (int s = 1; s < L; s++) pipe[s] <= pipe[s-1];
    end

    assign mem_rdata[g] = pipe[L-1];
  end

  // Reference model state
  logic [RS-1:0] model_mem [2][512];
  logic [RS-1:0] exp_mdata [2];
  logic [AW-1:0] exp_addr  [2];
  logic [RS-1:0] exp_wdata [2];

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : 4;
  endfunction

  // {busy, done, addr_err, mem_re, mem_we, mdr_in, md_mux_select}
  function automatic logic [6:0] ctl(input logic b, input logic d, input logic e,
                                     input logic re, input logic we, input logic m);
    return {b, d, e, re, we, m, m};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cycle(input int g, input string tag, input logic [6:0] exp_ctl);
    logic [6:0] obs_ctl;
    obs_ctl = {busy[g], done[g], addr_err[g], mem_re[g], mem_we[g], mdr_in[g], md_mux_select[g]};
    n_cmp++;
    assert (obs_ctl === exp_ctl) else begin
      n_fail++;
      $error("FAIL %s dut%0d ctl{busy,done,err,re,we,mdr,sel} got %b want %b", tag, g, obs_ctl, exp_ctl);
    end
    n_cmp++;
    assert (m_data_in[g] === exp_mdata[g]) else begin
      n_fail++;
      $error("FAIL %s dut%0d m_data_in got %h want %h", tag, g, m_data_in[g], exp_mdata[g]);
    end
    n_cmp++;
    assert (mem_addr[g] === exp_addr[g]) else begin
      n_fail++;
      $error("FAIL %s dut%0d mem_addr got %h want %h", tag, g, mem_addr[g], exp_addr[g]);
    end
    n_cmp++;
    assert (mem_wdata[g] === exp_wdata[g]) else begin
      n_fail++;
      $error("FAIL %s dut%0d mem_wdata got %h want %h", tag, g, mem_wdata[g], exp_wdata[g]);
    end
  endtask

  task automatic idle_check(input int g, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      chk_cycle(g, tag, 7'b0);
    end
  endtask

  function automatic bit out_of_range(input logic [RS-1:0] a);
`ifdef MEM_ADDR_CHECK_EN
    return a[RS-1:AW] != '0;
`else
    return 1'b0;
`endif
  endfunction

  // Error path: ERR for one cycle with done and addr_err, no RAM strobes.
  task automatic finish_err(input int g, input string tag);
    chk_cycle(g, tag, ctl(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    chk_cycle(g, {tag, "_idle"}, 7'b0);
  endtask

  // Read at address a. also_wr raises wr_req in the same cycle; poke keeps
  // re-requesting through RD_WAIT and RD_DONE. Returns in the first idle cycle.
  task automatic do_read(input int g, input logic [RS-1:0] a, input bit also_wr,
                         input bit poke, input string tag);
    int lat;
    lat = lat_of(g);
    rd_req[g]   = 1'b1;
    wr_req[g]   = also_wr;
    addr_in[g]  = a;
    wdata_in[g] = $urandom();
    tick();
    rd_req[g]   = 1'b0;
    wr_req[g]   = 1'b0;
    addr_in[g]  = $urandom();
    wdata_in[g] = $urandom();
    exp_addr[g] = a[AW-1:0];
    if (out_of_range(a)) begin
      finish_err(g, tag);
    end else begin
      for (int k = 1; k <= lat + 2; k++) begin
        if (k == lat + 2) exp_mdata[g] = model_mem[g][a[AW-1:0]];
        chk_cycle(g, tag, ctl(1'b1, k == lat + 2, 1'b0, k == 1, 1'b0, k == lat + 2));
        rd_req[g] = poke && (k >= 2);
        wr_req[g] = poke && (k >= 2) && ($urandom_range(0, 1) == 1);
        if (k < lat + 2) tick();
      end
      tick();
      rd_req[g] = 1'b0;
      wr_req[g] = 1'b0;
      chk_cycle(g, {tag, "_idle"}, 7'b0);
    end
  endtask

  task automatic do_write(input int g, input logic [RS-1:0] a, input logic [RS-1:0] d,
                          input string tag);
    wr_req[g]   = 1'b1;
    addr_in[g]  = a;
    wdata_in[g] = d;
    tick();
    wr_req[g]   = 1'b0;
    addr_in[g]  = $urandom();
    wdata_in[g] = $urandom();
    exp_addr[g]  = a[AW-1:0];
    exp_wdata[g] = d;
    if (out_of_range(a)) begin
      finish_err(g, tag);
    end else begin
      chk_cycle(g, tag, ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      tick();
      model_mem[g][a[AW-1:0]] = d;
      chk_cycle(g, tag, ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      tick();
      chk_cycle(g, {tag, "_idle"}, 7'b0);
    end
  endtask

  task automatic clear_model_regs();
    for (int g = 0; g < 2; g++) begin
      exp_mdata[g] = '0;
      exp_addr[g]  = '0;
      exp_wdata[g] = '0;
    end
  endtask

  initial begin
    logic [RS-1:0] a;
    logic [RS-1:0] d;
    logic [AW-1:0] a9;

    ram_seed = $urandom();
    reset    = 1'b1;
    ram_init = 1'b1;
    rd_req   = '0;
    wr_req   = '0;
    addr_in  = '0;
    wdata_in = '0;
    for (int g = 0; g < 2; g++)
      for (int i = 0; i < 512; i++) model_mem[g][i] = init_word(i);
    clear_model_regs();

    tick();
    tick();
    ram_init = 1'b0;
    tick();
    chk_cycle(0, "reset_state", 7'b0);
    chk_cycle(1, "reset_state", 7'b0);
    reset = 1'b0;
    tick();

    // Write then read back, MEM_LAT = 1.
    do_write(0, 32'h0000_0010, 32'hDEAD_BEEF, "t1_write");
    do_read (0, 32'h0000_0010, 1'b0, 1'b0, "t1_read");

    // Top of the address range, MEM_LAT = 4.
    do_read(1, 32'h0000_01FF, 1'b0, 1'b0, "t2_read_lat4");

    // Simultaneous read and write: read wins, RAM untouched.
    a9 = 9'($urandom_range(32, 200));
    do_read(0, {23'd0, a9}, 1'b1, 1'b0, "t3_rd_wr_tie");
    n_cmp++;
    assert (g_dut[0].ram[a9] === model_mem[0][a9]) else begin
      n_fail++;
      $error("FAIL t3_ram_unchanged got %h want %h", g_dut[0].ram[a9], model_mem[0][a9]);
    end

    // Requests during RD_WAIT / RD_DONE are dropped; the next cycle is accepted.
    do_read(1, 32'h0000_0055, 1'b0, 1'b1, "t4_poke");
    do_read(1, 32'h0000_0056, 1'b0, 1'b0, "t4_next");
    idle_check(1, 3, "t4_quiet");

    // Reset in RD_WAIT aborts the access.
    rd_req[1]  = 1'b1;
    addr_in[1] = 32'h0000_0077;
    tick();
    rd_req[1]  = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    clear_model_regs();
    chk_cycle(1, "t5_reset_mid", 7'b0);
    chk_cycle(0, "t5_reset_other", 7'b0);
    reset = 1'b0;
    idle_check(1, 6, "t5_no_done");
    do_read(1, 32'h0000_0077, 1'b0, 1'b0, "t5_after_reset");

    // Upper address bits: range error when checked, RAM word 0 otherwise.
    do_read(0, 32'h0000_0200, 1'b0, 1'b0, "t6_upper_bits");
    do_write(1, 32'h8000_0003, 32'h1234_5678, "t6_upper_write");
    do_read(1, 32'h0000_0003, 1'b0, 1'b0, "t6_readback");

    // Random traffic over a small address window so reads hit earlier writes.
    for (int n = 0; n < 40; n++) begin
      int g;
      int op;
      g  = $urandom_range(0, 1);
      op = $urandom_range(0, 2);
      a  = RS'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) a[RS-1:AW] = (RS-AW)'($urandom());
      d  = $urandom();
      case (op)
        0:       do_write(g, a, d, "rnd_write");
        1:       do_read (g, a, 1'b0, 1'b0, "rnd_read");
        default: do_read (g, a, 1'b1, 1'b0, "rnd_read_tie");
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
